// File: rtl/io_bridge_pkg.sv
// Shared types and defaults for the CPU-to-MMIO bridge.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package io_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Word index of each bridge register inside its own window.
    localparam logic [1:0] BR_WORD_IMASK   = 2'd0;
    localparam logic [1:0] BR_WORD_ISTAT   = 2'd1;
    localparam logic [1:0] BR_WORD_ERRADDR = 2'd2;

    localparam logic [31:0] BR_BASE_DEF    = 32'h0000_7f80;
    localparam logic [31:0] BR_LAST_OFS    = 32'd11;          // 3 words
    localparam logic [31:0] DEFAULT_RD_DEF = 32'h1723_ffff;
    localparam logic [5:0]  IMASK_RST      = 6'h3f;

    function automatic logic in_range(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/io_addr_decode.sv
// Range decoder: one-hot device hit, bridge-window hit and miss for a byte address.
// Latency: combinational.
// Backpressure: none; pure function of addr.
// Ports: addr in; dev_hit (one-hot, suppressed on a window hit), br_hit, miss out.
module io_addr_decode
    import io_bridge_pkg::*;
#(
    parameter int unsigned         N_DEV     = 6,
    parameter logic [N_DEV*32-1:0] DEV_BASE  = '0,
    parameter logic [N_DEV*32-1:0] DEV_LIMIT = '0,
    parameter logic [31:0]         BR_BASE   = BR_BASE_DEF
) (
    input  logic [31:0]      addr,
    output logic [N_DEV-1:0] dev_hit,
    output logic             br_hit,
    output logic             miss
);

    always_comb begin
        dev_hit = '0;
        br_hit  = in_range(addr, BR_BASE, BR_BASE + BR_LAST_OFS);
        for (int i = 0; i < int'(N_DEV); i++) begin
            // The bridge window outranks any device range that overlaps it.
            dev_hit[i] = !br_hit && in_range(addr, DEV_BASE[32*i +: 32], DEV_LIMIT[32*i +: 32]);
        end
        miss = !br_hit && !(|dev_hit);
    end

endmodule

// File: rtl/io_bridge_n.sv
// CPU-to-MMIO bridge: range decode, ack/timeout handshake, bridge registers, interrupt router.
// Latency: window/unmapped rdy 2 cycles after req sampled; device 2 + ack delay; hwint 2 cycles from dev_int.
// Backpressure: requester holds cpu_req until the one-cycle cpu_rdy pulse; devices stall via dev_ack up to TIMEOUT.
// Ports: cpu_* request/response side, dev_* peripheral side, hwint to CP0; clk with sync active-high reset.
module io_bridge_n
    import io_bridge_pkg::*;
#(
    parameter int unsigned         N_DEV      = 6,
    parameter logic [N_DEV*32-1:0] DEV_BASE   = {32'h7f50, 32'h7f40, 32'h7f30, 32'h7f20, 32'h7f10, 32'h7f00},
    parameter logic [N_DEV*32-1:0] DEV_LIMIT  = {32'h7f5b, 32'h7f4b, 32'h7f3b, 32'h7f2b, 32'h7f1b, 32'h7f0b},
    parameter logic [N_DEV*3-1:0]  INT_LINE   = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
    parameter logic [31:0]         BR_BASE    = BR_BASE_DEF,
    parameter int unsigned         TIMEOUT    = 15,
    parameter logic [31:0]         DEFAULT_RD = DEFAULT_RD_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wd,
    output logic                  cpu_rdy,
    output logic [31:0]           cpu_rd,
    output logic                  cpu_err,
    output logic [5:0]            hwint,
    output logic [N_DEV-1:0]      dev_sel,
    output logic                  dev_we,
    output logic [31:0]           dev_addr,
    output logic [31:0]           dev_wd,
    input  logic [N_DEV*32-1:0]   dev_rd,
    input  logic [N_DEV-1:0]      dev_ack,
    input  logic [N_DEV-1:0]      dev_int
);

    localparam logic [3:0] TO_CNT = 4'(TIMEOUT);

    state_t             state_q, state_d;
    logic [N_DEV-1:0]   dev_hit;
    logic               br_hit, miss;
    logic [2:0]         hit_idx, idx_q;
    logic [3:0]         cnt_q;
    logic [5:0]         imask_q, raw;
    logic [31:0]        erraddr_q, resp_rd_q, sel_rd, br_rdata;
    logic               resp_err_q, sel_ack, timed_out;
    logic [N_DEV-1:0]   int_q;
    logic [1:0]         br_word;

    io_addr_decode #(
        .N_DEV     (N_DEV),
        .DEV_BASE  (DEV_BASE),
        .DEV_LIMIT (DEV_LIMIT),
        .BR_BASE   (BR_BASE)
    ) u_dec (
        .addr    (cpu_addr),
        .dev_hit (dev_hit),
        .br_hit  (br_hit),
        .miss    (miss)
    );

    always_comb begin
        hit_idx = '0;
        sel_rd  = '0;
        sel_ack = 1'b0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            if (dev_hit[i])       hit_idx = 3'(i);
            if (idx_q == 3'(i)) begin
                sel_rd  = dev_rd[32*i +: 32];
                sel_ack = dev_ack[i];
            end
        end
    end

    // Each hwint line is the OR of every synchronised device interrupt routed to it.
    always_comb begin
        raw = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            for (int k = 0; k < 6; k++) begin
                if (INT_LINE[3*i +: 3] == 3'(k)) raw[k] = raw[k] | int_q[i];
            end
        end
    end

    assign br_word   = 2'((cpu_addr - BR_BASE) >> 2);
    assign timed_out = (cnt_q == TO_CNT);

    always_comb begin
        case (br_word)
            BR_WORD_IMASK:   br_rdata = {26'd0, imask_q};
            BR_WORD_ISTAT:   br_rdata = {26'd0, raw};
            BR_WORD_ERRADDR: br_rdata = erraddr_q;
            default:         br_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cpu_req) state_d = (|dev_hit) ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (sel_ack || timed_out) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdy    <= 1'b0;
            cpu_rd     <= '0;
            cpu_err    <= 1'b0;
            hwint      <= '0;
            dev_sel    <= '0;
            dev_we     <= 1'b0;
            dev_addr   <= '0;
            dev_wd     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            imask_q    <= IMASK_RST;
            erraddr_q  <= '0;
            resp_rd_q  <= '0;
            resp_err_q <= 1'b0;
            int_q      <= '0;
        end else begin
            int_q <= dev_int;
            hwint <= raw & imask_q;

            // Response flops present the result captured in RESP for one cycle.
            cpu_rdy <= (state_q == ST_RESP);
            cpu_rd  <= (state_q == ST_RESP) ? resp_rd_q  : '0;
            cpu_err <= (state_q == ST_RESP) ? resp_err_q : 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (br_hit) begin
                            resp_rd_q  <= br_rdata;
                            resp_err_q <= 1'b0;
                            // Only IMASK is writable; other window writes complete silently.
                            if (cpu_we && br_word == BR_WORD_IMASK) imask_q <= cpu_wd[5:0];
                        end else if (miss) begin
                            resp_rd_q  <= DEFAULT_RD;
                            resp_err_q <= 1'b1;
                            erraddr_q  <= cpu_addr;
                        end else begin
                            idx_q    <= hit_idx;
                            cnt_q    <= 4'd1;
                            dev_sel  <= dev_hit;
                            dev_we   <= cpu_we;
                            dev_addr <= cpu_addr;
                            dev_wd   <= cpu_wd;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ack || timed_out) begin
                        // Ack takes precedence over a timeout in the same cycle.
                        resp_rd_q  <= sel_ack ? sel_rd : DEFAULT_RD;
                        resp_err_q <= !sel_ack;
                        if (!sel_ack) erraddr_q <= dev_addr;
                        cnt_q    <= '0;
                        dev_sel  <= '0;
                        dev_we   <= 1'b0;
                        dev_addr <= '0;
                        dev_wd   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bridge_n.sv
module tb_io_bridge_n;
    localparam int N_DEV = 6;
    localparam logic [31:0] DEF_RD = 32'h1723ffff;

    logic                clk = 1'b0;
    logic                reset;
    logic                cpu_req, cpu_we;
    logic [31:0]         cpu_addr, cpu_wd;
    logic                cpu_rdy, cpu_err;
    logic [31:0]         cpu_rd;
    logic [5:0]          hwint;
    logic [N_DEV-1:0]    dev_sel;
    logic                dev_we;
    logic [31:0]         dev_addr, dev_wd;
    logic [N_DEV*32-1:0] dev_rd;
    logic [N_DEV-1:0]    dev_ack, dev_int;

    always #5 clk = ~clk;

    io_bridge_n dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rdy(cpu_rdy), .cpu_rd(cpu_rd),
        .cpu_err(cpu_err), .hwint(hwint), .dev_sel(dev_sel), .dev_we(dev_we),
        .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_rd(dev_rd), .dev_ack(dev_ack),
        .dev_int(dev_int)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [5:0]  imask_m   = 6'h3f;
    logic [31:0] erraddr_m = 32'd0;
    logic [5:0]  int_m     = 6'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // -1 unmapped, 0..5 device, 6 bridge window
    function automatic int region(input logic [31:0] a);
        if (a >= 32'h7f80 && a <= 32'h7f8b) return 6;
        for (int i = 0; i < N_DEV; i++)
            if (a >= 32'h7f00 + 32'(16*i) && a <= 32'h7f00 + 32'(16*i) + 32'd11) return i;
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One bus transaction, entered and left on a negedge. delay = ACCESS cycle
    // on which the selected device acks; anything above 15 never acks.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int delay, input string tag);
        logic [31:0]      data [N_DEV];
        int               rg, exp_lat, n, acc;
        logic [31:0]      exp_rd;
        logic             exp_err, chk_rd, got;
        logic [N_DEV-1:0] exp_sel;
        logic [5:0]       imask_next;
        logic [31:0]      erraddr_next;

        rg = region(addr);
        for (int i = 0; i < N_DEV; i++) begin
            data[i] = $urandom;
            dev_rd[32*i +: 32] = data[i];
        end
        imask_next   = imask_m;
        erraddr_next = erraddr_m;
        chk_rd       = 1'b1;
        exp_sel      = '0;
        if (rg == 6) begin
            exp_lat = 2; exp_err = 1'b0;
            case ((addr - 32'h7f80) >> 2)
                0:       exp_rd = {26'd0, imask_m};
                1:       exp_rd = {26'd0, int_m};
                default: exp_rd = erraddr_m;
            endcase
            if (we) begin
                chk_rd = 1'b0;
                if (((addr - 32'h7f80) >> 2) == 0) imask_next = wd[5:0];
            end
        end else if (rg < 0) begin
            exp_lat = 2; exp_err = 1'b1; exp_rd = DEF_RD; erraddr_next = addr;
        end else begin
            exp_sel = N_DEV'(1) << rg;
            if (delay <= 15) begin
                exp_lat = 2 + delay; exp_err = 1'b0; exp_rd = data[rg];
            end else begin
                exp_lat = 17; exp_err = 1'b1; exp_rd = DEF_RD; erraddr_next = addr;
            end
        end

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wd = wd;
        dev_ack = N_DEV'($urandom) & ~exp_sel;
        n = 0; acc = 0; got = 1'b0;
        while (n < 40 && !got) begin
            cyc();
            n++;
            if (cpu_rdy) begin
                got = 1'b1;
                cpu_req = 1'b0;
                chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
                chk({tag, "_err"}, 64'(cpu_err), 64'(exp_err));
                if (chk_rd) chk({tag, "_rd"}, 64'(cpu_rd), 64'(exp_rd));
            end else if (dev_sel != '0) begin
                acc++;
                chk({tag, "_sel"}, 64'(dev_sel), 64'(exp_sel));
                if (acc == 1) begin
                    chk({tag, "_dwe"}, 64'(dev_we), 64'(we));
                    chk({tag, "_daddr"}, 64'(dev_addr), 64'(addr));
                    if (we) chk({tag, "_dwd"}, 64'(dev_wd), 64'(wd));
                end
            end
            dev_ack = (N_DEV'($urandom) & ~exp_sel) | ((acc == delay && dev_sel != '0) ? exp_sel : '0);
        end
        if (!got) begin
            chk({tag, "_rdy_timeout"}, 64'(got), 64'(1));
            cpu_req = 1'b0;
        end
        dev_ack = '0;
        imask_m   = imask_next;
        erraddr_m = erraddr_next;
        cyc();
        chk({tag, "_rdy_pulse"}, 64'(cpu_rdy), 64'(0));
        chk({tag, "_sel_idle"}, 64'(dev_sel), 64'(0));
        chk({tag, "_hwint"}, 64'(hwint), 64'(int_m & imask_m));
    endtask

    task automatic set_int(input logic [5:0] v);
        dev_int = v;
        int_m   = v;
        cyc();
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cat, d, rdy_seen;
        logic [31:0] a;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
        dev_rd = '0; dev_ack = '0; dev_int = '0;
        cyc(); cyc();
        chk("rst_rdy",   64'(cpu_rdy),  0);
        chk("rst_rd",    64'(cpu_rd),   0);
        chk("rst_err",   64'(cpu_err),  0);
        chk("rst_hwint", 64'(hwint),    0);
        chk("rst_sel",   64'(dev_sel),  0);
        chk("rst_dwe",   64'(dev_we),   0);
        chk("rst_daddr", 64'(dev_addr), 0);
        chk("rst_dwd",   64'(dev_wd),   0);
        reset = 1'b0;
        cyc();

        access(1'b0, 32'h7f04, 32'd0, 3, "t1");
        access(1'b1, 32'h7f14, 32'h55, 4, "t2");
        access(1'b0, 32'h12340000, 32'd0, 0, "t3");
        access(1'b0, 32'h7f88, 32'd0, 0, "t3_erraddr");
        chk("t3_erraddr_const", 64'(erraddr_m), 64'(32'h12340000));
        access(1'b0, 32'h7f20, 32'd0, 99, "t4_to");
        access(1'b0, 32'h7f24, 32'd0, 15, "t4_ack15");
        access(1'b0, 32'h7f28, 32'd0, 14, "t4_ack14");
        access(1'b0, 32'h7f88, 32'd0, 0, "t4_erraddr");

        // Boundaries of ranges and window
        access(1'b0, 32'h7f00, 32'd0, 1, "b_base0");
        access(1'b0, 32'h7f0b, 32'd0, 2, "b_lim0");
        access(1'b0, 32'h7f0c, 32'd0, 0, "b_gap0");
        access(1'b0, 32'h7f5b, 32'd0, 1, "b_lim5");
        access(1'b0, 32'h7f7f, 32'd0, 0, "b_below_br");
        access(1'b0, 32'h7f8c, 32'd0, 0, "b_above_br");
        access(1'b1, 32'h7f84, 32'hffff, 0, "b_wr_istat");
        access(1'b1, 32'h7f88, 32'h1, 0, "b_wr_erraddr");
        access(1'b0, 32'h7f88, 32'd0, 0, "b_erraddr_kept");

        // Interrupt routing and masking
        access(1'b1, 32'h7f80, 32'h3f, 0, "t5_imask_on");
        dev_int = 6'h20;
        cyc();
        chk("t5_hwint_c1", 64'(hwint), 0);
        cyc();
        chk("t5_hwint_c2", 64'(hwint), 64'(6'h20));
        int_m = 6'h20;
        access(1'b1, 32'h7f80, 32'h1f, 0, "t5_imask_1f");
        chk("t5_hwint_masked", 64'(hwint), 0);
        access(1'b0, 32'h7f84, 32'd0, 0, "t5_istat");
        access(1'b0, 32'h7f80, 32'd0, 0, "t5_imask_rd");
        set_int(6'h00);

        // Reset in the second ACCESS cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7f20; dev_ack = '0;
        cyc();
        chk("t6_sel_c1", 64'(dev_sel), 64'(6'b000100));
        cyc();
        chk("t6_sel_c2", 64'(dev_sel), 64'(6'b000100));
        reset = 1'b1; cpu_req = 1'b0;
        cyc();
        reset = 1'b0;
        chk("t6_sel_after", 64'(dev_sel), 0);
        imask_m = 6'h3f; erraddr_m = 32'd0;
        rdy_seen = 0;
        repeat (20) begin
            if (cpu_rdy) rdy_seen++;
            cyc();
        end
        chk("t6_no_rdy", 64'(rdy_seen), 0);
        access(1'b0, 32'h7f80, 32'd0, 0, "t6_imask");
        access(1'b0, 32'h7f88, 32'd0, 0, "t6_erraddr");

        // Randomised traffic
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) == 0) set_int(6'($urandom));
            cat = int'($urandom_range(0, 3));
            case (cat)
                0: a = 32'h7f00 + 32'(16 * $urandom_range(0, 5)) + 32'($urandom_range(0, 11));
                1: a = 32'h7f80 + 32'(4 * $urandom_range(0, 2));
                2: a = $urandom;
                default: a = 32'h7f00 + 32'($urandom_range(0, 160));
            endcase
            d = int'($urandom_range(1, 16));
            access(1'($urandom), a, $urandom, d, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
